// File: rtl/riscv_pkg.sv
// Shared ALU opcode constants, redirect FSM state type and default halt address.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // ALU operation codes the redirect logic cares about
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BEQ  = 4'b1101;
    localparam logic [3:0] ALU_JAL  = 4'b1110;
    localparam logic [3:0] ALU_JALR = 4'b1111;

    // A control transfer to this address stops the core
    localparam logic [8:0] HALT_PC_DEFAULT = 9'h1FC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        HALTED   = 2'd2
    } redir_state_e;

endpackage

// File: rtl/redirect_target_calc.sv
// Decides whether the EX instruction transfers control, where to, and whether that target halts the core.
// Latency: purely combinational.
// Backpressure: stall suppresses take; no internal state.
module redirect_target_calc
    import riscv_pkg::*;
#(
    parameter int              DATA_WIDTH    = 32,
    parameter int              OPCODE_LENGTH = 4,
    parameter int              PC_W          = 9,
    parameter logic [PC_W-1:0] HALT_PC       = HALT_PC_DEFAULT[PC_W-1:0]
) (
    input  logic                     ex_valid,
    input  logic                     stall,
    input  logic                     branch,
    input  logic                     jal,
    input  logic                     jalr,
    input  logic [OPCODE_LENGTH-1:0] operation,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic [DATA_WIDTH-1:0]    jalr_src,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [PC_W-1:0]          curr_pc,
    output logic                     take,
    output logic [PC_W-1:0]          target,
    output logic                     halt_req
);

    logic cmp_op;
    logic unused_bits;

    // Only the compare bit of the ALU result and the low PC bits of the addends matter
    assign unused_bits = ^{alu_result[DATA_WIDTH-1:1], jalr_src[DATA_WIDTH-1:PC_W],
                           jalr_src[0], imm[DATA_WIDTH-1:PC_W]};

    // Decode branch type, resolve target (jalr wins over jal/branch) and flag halting targets
    always_comb begin
        cmp_op   = (operation == OPCODE_LENGTH'(ALU_BNE)) ||
                   (operation == OPCODE_LENGTH'(ALU_BLT)) ||
                   (operation == OPCODE_LENGTH'(ALU_BGE)) ||
                   (operation == OPCODE_LENGTH'(ALU_BEQ));
        take     = ex_valid & ~stall & (jal | jalr | (branch & cmp_op & alu_result[0]));
        target   = '0;
        if (jalr) begin
            target = {jalr_src[PC_W-1:1], 1'b0};
        end else begin
            // PC-relative; overflow past the top of the PC space wraps silently
            target = curr_pc + imm[PC_W-1:0];
        end
        // jalr targets already have bit 0 cleared, so this reduces to a bit-1 check for them
        halt_req = take & ((target == HALT_PC) | (target[1:0] != 2'b00));
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Turns EX-stage branch/jump resolution into a registered PC redirect plus IF/ID and ID/EX flushes, and halts on bad targets.
// Latency: redirect appears 1 cycle after the taken instruction is seen in EX.
// Backpressure: stall freezes state, outputs and counter (a pending redirect pulse is stretched).
module branch_redirect_unit
    import riscv_pkg::*;
#(
    parameter int              DATA_WIDTH    = 32,
    parameter int              OPCODE_LENGTH = 4,
    parameter int              PC_W          = 9,
    parameter logic [PC_W-1:0] HALT_PC       = HALT_PC_DEFAULT[PC_W-1:0],
    parameter int              CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     stall,
    input  logic                     ex_valid,
    input  logic                     branch,
    input  logic                     jal,
    input  logic                     jalr,
    input  logic [OPCODE_LENGTH-1:0] operation,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic [DATA_WIDTH-1:0]    jalr_src,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [PC_W-1:0]          curr_pc,
    output logic                     pc_sel,
    output logic [PC_W-1:0]          pc_target,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic                     halt,
    output logic [CNT_W-1:0]         redirect_count
);

    redir_state_e     state_q, state_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pc_sel_q, flush_q, halt_q;

    logic             take;
    logic [PC_W-1:0]  calc_target;
    logic             halt_req;

    redirect_target_calc #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH),
        .PC_W          (PC_W),
        .HALT_PC       (HALT_PC)
    ) u_target_calc (
        .ex_valid   (ex_valid),
        .stall      (stall),
        .branch     (branch),
        .jal        (jal),
        .jalr       (jalr),
        .operation  (operation),
        .alu_result (alu_result),
        .jalr_src   (jalr_src),
        .imm        (imm),
        .curr_pc    (curr_pc),
        .take       (take),
        .target     (calc_target),
        .halt_req   (halt_req)
    );

    // Next-state logic: EX inputs only matter in IDLE; REDIRECT lasts one unstalled cycle; HALTED is terminal
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (halt_req) begin
                        state_d = HALTED;
                    end else begin
                        state_d  = REDIRECT;
                        target_d = calc_target;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
            end
            REDIRECT: begin
                // Whatever sits in EX now is wrong-path, so it is never looked at here
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, target, counter and output registers; outputs are decoded from the next state so they leave flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            pc_sel_q <= 1'b0;
            flush_q  <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            pc_sel_q <= (state_d == REDIRECT);
            flush_q  <= (state_d != IDLE);
            halt_q   <= (state_d == HALTED);
        end
    end

    assign pc_sel         = pc_sel_q;
    assign pc_target      = target_q;
    assign flush_if_id    = flush_q;
    assign flush_id_ex    = flush_q;
    assign halt           = halt_q;
    assign redirect_count = count_q;

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumes the execute-stage ALU outputs (compare result, link/jalr target) and turns them into registered PC redirects and pipeline flushes for IF/ID and ID/EX.
- Reads the ALU's branch-compare opcodes (bne/blt/bge/beq) and its JAL/JALR outputs.
- Sits between EX and the PC/fetch logic.
- Also implements processor halt: any control transfer to HALT_PC or to a misaligned target stops the core.

Parameters:
- DATA_WIDTH, 32, ALU data width.
- OPCODE_LENGTH, 4, ALU operation code width.
- PC_W, 9, program counter width.
- HALT_PC, 9'h1FC, target that requests halt.
- CNT_W, 16, redirect counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold; freezes this unit.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- branch  in  1  EX instruction is a conditional branch.
- jal  in  1  EX instruction is JAL.
- jalr  in  1  EX instruction is JALR.
- operation  in  OPCODE_LENGTH  ALU operation of EX instruction.
- alu_result  in  DATA_WIDTH  ALU result; bit 0 is the compare outcome.
- jalr_src  in  DATA_WIDTH  rs1+imm from ALU.
- imm  in  DATA_WIDTH  sign-extended B/J immediate.
- curr_pc  in  PC_W  PC of EX instruction.
- pc_sel  out  1  fetch must load pc_target this cycle.
- pc_target  out  PC_W  redirect target.
- flush_if_id  out  1  kill IF/ID contents.
- flush_id_ex  out  1  kill ID/EX contents.
- halt  out  1  core halted (sticky).
- redirect_count  out  CNT_W  taken redirects since reset, saturating.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; pc_sel, flush_if_id, flush_id_ex, halt = 0; pc_target = 0; redirect_count = 0. Reset mid-REDIRECT or in HALTED returns to IDLE immediately.
- Branch-compare opcodes: 4'b1010 bne, 4'b1011 blt, 4'b1100 bge, 4'b1101 beq. A branch with any other operation is not taken.
- take = ex_valid & ~stall & (jal | jalr | (branch & cmp_op & alu_result[0])).
- Target:
  - jal/branch: (curr_pc + imm[PC_W-1:0]) mod 2^PC_W; wrap-around is silent.
  - jalr: {jalr_src[PC_W-1:1], 1'b0}.
  - Priority: jalr > jal > branch when more than one flag is set.
- Halt condition: take & (target == HALT_PC | target[1:0] != 0). For jalr, only target[1] is checked for misalignment after bit-0 clear.
- FSM states: IDLE, REDIRECT, HALTED.
- IDLE:
  - take & ~halt condition -> REDIRECT. Latch pc_target; increment redirect_count unless it is all-ones.
  - take & halt condition -> HALTED.
  - Otherwise stay in IDLE.
- REDIRECT (exactly one cycle, so redirect latency is 1 cycle):
  - pc_sel=1, flush_if_id=1, flush_id_ex=1.
  - EX inputs this cycle are wrong-path and are ignored even if take is asserted.
  - Next state: IDLE.
- HALTED:
  - halt=1, pc_sel=0, flush_if_id=1, flush_id_ex=1, held until reset.
  - All inputs ignored; counter frozen.
- stall=1: state, all outputs and the counter hold their values, including mid-REDIRECT. That cycle's REDIRECT pulse is extended until the first cycle with stall=0, then completes.
- Outputs are registered (Moore, decoded from state plus latched target); no combinational path from inputs to outputs.
- pc_target holds its last latched value outside REDIRECT.
- ex_valid=0 with branch/jal/jalr set produces no redirect (bubble).

Decomposition:
- Shared package (riscv_pkg): opcode constants ALU_BNE/BLT/BGE/BEQ/JAL (4'b1010..4'b1111), the state enum typedef (IDLE/REDIRECT/HALTED), and the HALT_PC default.
- One natural sub-module: redirect_target_calc, the combinational target computation plus misalign/halt check.
- Counter and FSM live in the top module.

Test Plan:
- Reset: reset_n=0 mid-operation -> all outputs 0 asynchronously, before the next clk edge; after release, state IDLE.
- Taken beq: ex_valid=1, branch=1, operation=4'b1101, alu_result=1, curr_pc=9'h010, imm=32'h0000_0020 -> next cycle pc_sel=1, pc_target=9'h030, both flushes=1 for one cycle; redirect_count=1.
- Not-taken branch and bubble: bne with alu_result=0 -> no pc_sel; then jal=1 with ex_valid=0 -> no pc_sel, count unchanged.
- jalr and wrong-path suppression: jalr=1, jalr_src=32'h0000_0045 -> pc_target=9'h044, pc_sel for one cycle. A jal presented during the REDIRECT cycle is ignored; count increments by 1 only.
- Wrap and halt:
  - curr_pc=9'h1F0, imm=32'h0000_0020 -> pc_target=9'h010.
  - jal with target 9'h1FC -> halt=1 and flushes held 1 for 20+ cycles, pc_sel=0.
  - Misaligned branch target 9'h012 -> halt=1.
- Stall and saturation:
  - stall=1 asserted in the REDIRECT cycle for 3 cycles -> pc_sel stays 1 until stall drops, then a single deassert.
  - Preload via 65535 redirects (or CNT_W=4 override, 15 redirects) -> counter stays at all-ones on the next redirect.
